fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one sync FIFO write port (2..16).
REQ-002 Parameter DATA_WIDTH, default 8, beat width; equals the FIFO data width.
REQ-003 Parameter MAX_BURST, default 16, maximum beats per grant (1..255).
REQ-004 Derived constant ID_WIDTH = max(1, clog2(NUM_REQ)).
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  beats, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_last  input  NUM_REQ  final beat of a packet, qualified by req_valid.
REQ-010 req_ready  output  NUM_REQ  per-requester accept, at most one bit set.
REQ-011 fifo_full  input  1  full flag from the downstream FIFO.
REQ-012 fifo_wr_en  output  1  FIFO write strobe.
REQ-013 fifo_wr_data  output  DATA_WIDTH  FIFO write data.
REQ-014 fifo_wr_id  output  ID_WIDTH  index of the requester that sourced fifo_wr_data.
REQ-015 grant  output  NUM_REQ  one-hot current owner, all-zero when idle.

Function
REQ-016 FSM states: IDLE, ARB, XFER.
REQ-017 IDLE: when any req_valid is 1, go to ARB next cycle; otherwise stay.
REQ-018 ARB: pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ; register it into grant; go to XFER. If no valid remains, return to IDLE with grant zero.
REQ-019 XFER: req_ready[g] = grant[g] AND stage_free; all other req_ready bits are 0.
REQ-020 A beat is accepted when req_valid[g] AND req_ready[g] are both 1. On acceptance, data and the index are captured into a one-entry output stage, and the beat counter increments.
REQ-021 stage_free = output stage empty OR (fifo_wr_en this cycle); this gives full throughput with no combinational path from req_valid to fifo_wr_en.
REQ-022 fifo_wr_en = output stage valid AND NOT fifo_full; the stage empties when fifo_wr_en is 1.
REQ-023 fifo_full = 1 holds the stage contents and drops req_ready. No beat is lost or duplicated.
REQ-024 Grant release: on the accepted beat that satisfies the release condition (REQ-033/034), or when the beat counter reaches MAX_BURST. Release clears grant, sets rr_ptr = (g+1) mod NUM_REQ, clears the beat counter and moves to ARB. The earliest new grant is 2 cycles later, which is the arbitration bubble.
REQ-025 Deassertion of req_valid[g] during XFER does not release the grant.
REQ-026 Wrap-around: requester NUM_REQ-1 releases to pointer 0.
REQ-027 Starvation bound: with all requesters active, each receives a grant within NUM_REQ grant periods.

Reset
REQ-028 On rst_n low, regardless of clk: state IDLE, grant 0, rr_ptr 0, beat counter 0, output stage empty.
REQ-029 Reset values of outputs: req_ready 0, fifo_wr_en 0, fifo_wr_data 0, fifo_wr_id 0, grant 0.
REQ-030 Reset during XFER discards any staged beat; no FIFO write occurs until a new beat is accepted after rst_n rises.
REQ-031 The first ARB after reset starts from requester 0.

Configuration
REQ-032 Macro FIFO_WR_ARBITER_PKT_LOCK_EN selects the release condition.
REQ-033 When FIFO_WR_ARBITER_PKT_LOCK_EN is defined, the grant is held until the accepted beat has req_last = 1 (or the MAX_BURST cap is reached); packets stay contiguous in the FIFO.
REQ-034 When FIFO_WR_ARBITER_PKT_LOCK_EN is not defined, req_last is ignored and the grant releases after every accepted beat (beat-level round-robin).

Structure
REQ-035 Shared package fifo_arb_pkg holds the FSM state enum (IDLE/ARB/XFER) and the ID_WIDTH computation function.
REQ-036 Sub-module rr_arbiter (NUM_REQ parameter; inputs req vector and rr_ptr; outputs one-hot winner and found flag) is purely combinational and instantiated once.

Verification
REQ-037 Single requester 0 sends beats 0x11, 0x22, 0x33 with fifo_full=0 -> fifo_wr_en pulses carry 0x11, 0x22, 0x33 in order with id 0, and each grant is preceded by the 2-cycle bubble.
REQ-038 All 4 requesters continuously valid, lock off -> id sequence 0,1,2,3,0,1... with exactly one beat per grant.
REQ-039 Lock on, requester 2 sends a 5-beat packet (last on beat 5) while requester 1 is valid -> 5 contiguous id=2 writes, then requester 1 is granted.
REQ-040 Lock on, requester 0 streams 20 beats with no last, MAX_BURST=16 -> release after 16 beats, then rr_ptr=1.
REQ-041 fifo_full held high for 10 cycles mid-stream -> fifo_wr_en stays 0, req_ready stays 0, and the staged beat is written once after full drops.
REQ-042 rst_n asserted while a beat is staged and fifo_full=1 -> all outputs go to 0 immediately, and there is no write after release until new valid input arrives.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state encoding and requester-index width helper for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after rr_ptr, wrapping.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  winner,
  output logic                found
);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        winner[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one sync FIFO write port through a one-entry output stage.
// Define FIFO_WR_ARBITER_PKT_LOCK_EN to hold the grant until req_last (packet lock); default releases per beat.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  localparam int ID_WIDTH  = id_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic [ID_WIDTH-1:0]             fifo_wr_id,
  output logic [NUM_REQ-1:0]              grant
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d, winner;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d, gidx;
  logic [7:0]            cnt_q, cnt_d;
  logic                  stage_vld_q, stage_vld_d;
  logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d, sel_data;
  logic [ID_WIDTH-1:0]   stage_id_q, stage_id_d;
  logic                  found, stage_free, accept, last_ok, release_g;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .found  (found)
  );

  // The stage can take a new beat in the same cycle it drains, so req_ready never depends on req_valid.
  assign fifo_wr_en   = stage_vld_q & ~fifo_full;
  assign stage_free   = ~stage_vld_q | fifo_wr_en;
  assign req_ready    = (state_q == XFER && stage_free) ? grant_q : '0;
  assign accept       = |(req_valid & req_ready);
  assign fifo_wr_data = stage_data_q;
  assign fifo_wr_id   = stage_id_q;
  assign grant        = grant_q;

`ifdef FIFO_WR_ARBITER_PKT_LOCK_EN
  assign last_ok = |(req_last & grant_q);
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign last_ok     = 1'b1;
`endif

  assign release_g = accept & (last_ok | (cnt_q + 8'd1 == BURST_MAX));

  always_comb begin
    gidx     = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        gidx     = ID_WIDTH'(i);
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    stage_vld_d  = accept | (stage_vld_q & ~fifo_wr_en);
    stage_data_d = accept ? sel_data : stage_data_q;
    stage_id_d   = accept ? gidx : stage_id_q;
    case (state_q)
      IDLE: state_d = |req_valid ? ARB : IDLE;
      ARB: begin
        state_d = found ? XFER : IDLE;
        grant_d = found ? winner : '0;
      end
      XFER: begin
        state_d  = release_g ? ARB : XFER;
        grant_d  = release_g ? '0 : grant_q;
        cnt_d    = release_g ? 8'd0 : cnt_q + 8'(accept);
        rr_ptr_d = !release_g ? rr_ptr_q :
                   (gidx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gidx + ID_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      stage_vld_q  <= 1'b0;
      stage_data_q <= '0;
      stage_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      stage_vld_q  <= stage_vld_d;
      stage_data_q <= stage_data_d;
      stage_id_q   <= stage_id_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of fifo_wr_arbiter with queue-fed requesters and a write recorder.
module tb_fifo_wr_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready, grant;
  logic           fifo_wr_en;
  logic [7:0]     fifo_wr_data;
  logic [1:0]     fifo_wr_id;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] src [N][$];
  logic [7:0] wr_data [$];
  logic [1:0] wr_id [$];
  int         wr_cyc [$];

  fifo_wr_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_id   (fifo_wr_id),
    .grant        (grant)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (fifo_wr_en) begin
      wr_data.push_back(fifo_wr_data);
      wr_id.push_back(fifo_wr_id);
      wr_cyc.push_back(cyc);
    end
  end

  // Each requester presents the head of its queue and pops it once the handshake completes.
  initial begin
    logic [N-1:0] acc;
    logic [8:0]   b;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
        req_valid[i] = src[i].size() > 0;
        b = (src[i].size() > 0) ? src[i][0] : 9'd0;
        req_data[i*8 +: 8] = b[7:0];
        req_last[i] = b[8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input int n);
    for (int k = 0; k < 400 && wr_data.size() < n; k++) @(posedge clk);
    #1;
    chk("wr_count_timeout", 32'(wr_data.size() >= n), 32'd1);
  endtask

  task automatic chk_wr(input int k, input logic [1:0] id, input logic [7:0] d);
    chk($sformatf("wr%0d_present", k), 32'(wr_data.size() > k), 32'd1);
    if (wr_data.size() > k) begin
      chk($sformatf("wr%0d_id", k), 32'(wr_id[k]), 32'(id));
      chk($sformatf("wr%0d_data", k), 32'(wr_data[k]), 32'(d));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    chk({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
    chk({tag, "_wr_id"}, 32'(fifo_wr_id), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic clear_wr;
    wr_data.delete();
    wr_id.delete();
    wr_cyc.delete();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) src[i].delete();
    cyc_wait(3);
    rst_n = 1'b1;
    clear_wr();
  endtask

  initial begin
    logic bad, held;
    cyc_wait(3);
    chk_outputs_zero("rst");
    rst_n = 1'b1;
    cyc_wait(2);

    // single requester: one write every two cycles because of the arbitration bubble
    src[0].push_back(9'h111);
    src[0].push_back(9'h122);
    src[0].push_back(9'h133);
    wait_wr(3);
    chk_wr(0, 2'd0, 8'h11);
    chk_wr(1, 2'd0, 8'h22);
    chk_wr(2, 2'd0, 8'h33);
    if (wr_cyc.size() >= 3) begin
      chk("bubble_01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd2);
      chk("bubble_12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);
    end

    // all requesters busy: strict 0,1,2,3 rotation, one beat each
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++) src[i].push_back({1'b1, 8'(i * 16 + j)});
    wait_wr(12);
    for (int k = 0; k < 12; k++) chk_wr(k, 2'(k % 4), 8'((k % 4) * 16 + k / 4));

    // FIFO full mid-stream: staged beat held, no ready, then written exactly once
    do_reset();
    for (int j = 0; j < 4; j++) src[0].push_back({1'b1, 8'(8'hA0 + j)});
    wait_wr(1);
    cyc_wait(1);
    fifo_full = 1'b1;
    bad = 1'b0;
    held = 1'b1;
    repeat (10) begin
      @(negedge clk);
      bad |= fifo_wr_en | (|req_ready);
      held &= (fifo_wr_data === 8'hA1);
    end
    chk("full_no_wr_no_ready", 32'(bad), 32'd0);
    chk("full_stage_held", 32'(held), 32'd1);
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    wait_wr(4);
    cyc_wait(10);
    chk("full_wr_count", 32'(wr_data.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk_wr(k, 2'd0, 8'(8'hA0 + k));

    // async reset with a staged beat blocked by full: outputs clear at once, staged beat discarded
    do_reset();
    fifo_full = 1'b1;
    src[0].push_back(9'h1C5);
    src[0].push_back(9'h1C6);
    cyc_wait(8);
    chk("staged_before_rst", 32'(fifo_wr_data), 32'hC5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) src[i].delete();
    fifo_full = 1'b0;
    cyc_wait(3);
    rst_n = 1'b1;
    clear_wr();
    cyc_wait(10);
    chk("no_wr_after_rst", 32'(wr_data.size()), 32'd0);
    src[0].push_back(9'h15A);
    wait_wr(1);
    chk_wr(0, 2'd0, 8'h5A);

`ifdef FIFO_WR_ARBITER_PKT_LOCK_EN
    // packet lock: requester 2's 5-beat packet stays contiguous ahead of requester 1
    do_reset();
    for (int j = 0; j < 5; j++) src[2].push_back({1'(j == 4), 8'(8'h21 + j)});
    wait_wr(1);
    src[1].push_back(9'h131);
    wait_wr(6);
    for (int k = 0; k < 5; k++) chk_wr(k, 2'd2, 8'(8'h21 + k));
    chk_wr(5, 2'd1, 8'h31);

    // burst cap: 16 beats from requester 0, then requester 1, then requester 0 resumes
    do_reset();
    for (int j = 0; j < 20; j++) src[0].push_back({1'b0, 8'(8'h40 + j)});
    src[1].push_back(9'h199);
    wait_wr(21);
    for (int k = 0; k < 16; k++) chk_wr(k, 2'd0, 8'(8'h40 + k));
    chk_wr(16, 2'd1, 8'h99);
    for (int k = 17; k < 21; k++) chk_wr(k, 2'd0, 8'(8'h40 + k - 1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
